// File: rtl/mem_io_pkg.sv
// Shared constants and the inbound queue entry type for the memory mesh io
// bridge. The mesh is built from the same constants, so changing them here
// changes both sides together.
package mem_io_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int IO_PORTS   = 8;
    localparam int PORT_WIDTH = 3;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [PORT_WIDTH-1:0] port;
        logic [DATA_WIDTH-1:0] data;
    } mio_entry_t;

    localparam int ENTRY_WIDTH = $bits(mio_entry_t);

endpackage

// File: rtl/mem_io_fifo.sv
// Generic synchronous FIFO with synchronous active-low reset.
// Ports:
//   clk, rst_n      clock, synchronous reset (active low)
//   push, wr_data   write side; ignored while full
//   pop, rd_data    read side; rd_data shows the head, pop ignored while empty
//   full, empty     occupancy flags
//   count           number of stored entries
module mem_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == (AW+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;

    // Storage needs no reset: nothing is read until a push has written it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between a host and the memory mesh io ports.
// Inbound: host writes are queued and replayed into the mesh as one-cycle
// one-hot strobes, at most one port per cycle, paused by io_hold.
// Outbound: every mesh io_active_out pulse is captured per port with a fresh
// flag; the host reads ports back, and fresh & irq_mask drives irq.
// Ports:
//   clk, rst_n                       clock, synchronous reset (active low)
//   hw_valid/hw_ready/hw_port/hw_data  host write handshake
//   io_hold                          stall replay into the mesh
//   io_active_in, io_data_in         registered strobes/data to the mesh
//   io_active_out, io_data_out       writes reported by the mesh
//   hr_req/hr_port -> hr_valid/hr_data/hr_fresh   host readback
//   irq_mask, irq                    interrupt on unread captured data
//   err_oob                          sticky: out-of-range write dropped
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int NUM_PORTS = IO_PORTS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            hw_valid,
    output logic                            hw_ready,
    input  logic [PORT_WIDTH-1:0]           hw_port,
    input  logic [DATA_WIDTH-1:0]           hw_data,
    input  logic                            io_hold,
    output logic [NUM_PORTS-1:0]            io_active_in,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] io_data_in,
    input  logic [NUM_PORTS-1:0]            io_active_out,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] io_data_out,
    input  logic                            hr_req,
    input  logic [PORT_WIDTH-1:0]           hr_port,
    output logic                            hr_valid,
    output logic [DATA_WIDTH-1:0]           hr_data,
    output logic                            hr_fresh,
    input  logic [NUM_PORTS-1:0]            irq_mask,
    output logic                            irq,
    output logic                            err_oob
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    mio_entry_t                      w_wr_entry;
    mio_entry_t                      w_head;
    logic                            w_full;
    logic                            w_empty;
    logic [CNT_W-1:0]                w_count;
    logic                            w_port_ok;
    logic                            w_push;
    logic                            w_oob_drop;
    logic                            w_pop;
    logic [NUM_PORTS-1:0]            w_act_next;
    logic [NUM_PORTS*DATA_WIDTH-1:0] w_dat_next;
    logic [NUM_PORTS-1:0]            w_rd_sel;
    logic [DATA_WIDTH-1:0]           w_rd_data;
    logic                            w_rd_fresh;

    logic [NUM_PORTS-1:0]            r_active;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0]           r_cap_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]            r_fresh;
    logic                            r_hr_valid;
    logic [DATA_WIDTH-1:0]           r_hr_data;
    logic                            r_hr_fresh;
    logic                            r_err_oob;

    // Out-of-range writes still complete the handshake; they are just dropped.
    assign w_port_ok  = (int'(hw_port) < NUM_PORTS);
    assign hw_ready   = !w_full;
    assign w_push     = hw_valid && hw_ready && w_port_ok;
    assign w_oob_drop = hw_valid && hw_ready && !w_port_ok;
    assign w_pop      = !io_hold && !w_empty;
    assign w_wr_entry = '{port: hw_port, data: hw_data};

    mem_io_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_wr_entry),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    a_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
        w_full == (w_count == CNT_W'(FIFO_DEPTH)));

    always_comb begin
        w_act_next = '0;
        w_dat_next = '0;
        if (w_pop) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_head.port == PORT_WIDTH'(p)) begin
                    w_act_next[p]                           = 1'b1;
                    w_dat_next[p*DATA_WIDTH +: DATA_WIDTH]  = w_head.data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= '0;
            r_data   <= '0;
        end else begin
            r_active <= w_act_next;
            r_data   <= w_dat_next;
        end
    end

    // An out-of-range hr_port selects nothing, so it reads as zero.
    always_comb begin
        w_rd_sel   = '0;
        w_rd_data  = '0;
        w_rd_fresh = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (hr_port == PORT_WIDTH'(p)) begin
                w_rd_sel[p] = 1'b1;
                w_rd_data   = r_cap_data[p];
                w_rd_fresh  = r_fresh[p];
            end
        end
    end

    // A capture on the port being read wins over the read's fresh-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cap_data[p] <= '0;
            end
            r_fresh    <= '0;
            r_hr_valid <= 1'b0;
            r_hr_data  <= '0;
            r_hr_fresh <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            r_hr_valid <= hr_req;
            if (hr_req) begin
                r_hr_data  <= w_rd_data;
                r_hr_fresh <= w_rd_fresh;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (io_active_out[p]) begin
                    r_cap_data[p] <= io_data_out[p*DATA_WIDTH +: DATA_WIDTH];
                    r_fresh[p]    <= 1'b1;
                end else if (hr_req && w_rd_sel[p]) begin
                    r_fresh[p]    <= 1'b0;
                end
            end
            if (w_oob_drop) begin
                r_err_oob <= 1'b1;
            end
        end
    end

    assign io_active_in = r_active;
    assign io_data_in   = r_data;
    assign hr_valid     = r_hr_valid;
    assign hr_data      = r_hr_data;
    assign hr_fresh     = r_hr_fresh;
    assign irq          = |(r_fresh & irq_mask);
    assign err_oob      = r_err_oob;

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hw_valid;
    logic         hw_ready;
    logic [2:0]   hw_port;
    logic [15:0]  hw_data;
    logic         io_hold;
    logic [7:0]   io_active_in;
    logic [127:0] io_data_in;
    logic [7:0]   io_active_out;
    logic [127:0] io_data_out;
    logic         hr_req;
    logic [2:0]   hr_port;
    logic         hr_valid;
    logic [15:0]  hr_data;
    logic         hr_fresh;
    logic [7:0]   irq_mask;
    logic         irq;
    logic         err_oob;

    // Second instance with six ports so that out-of-range indices exist.
    logic         hw_valid6;
    logic         hw_ready6;
    logic [2:0]   hw_port6;
    logic [15:0]  hw_data6;
    logic         io_hold6;
    logic [5:0]   io_active_in6;
    logic [95:0]  io_data_in6;
    logic [5:0]   io_active_out6;
    logic [95:0]  io_data_out6;
    logic         hr_req6;
    logic [2:0]   hr_port6;
    logic         hr_valid6;
    logic [15:0]  hr_data6;
    logic         hr_fresh6;
    logic [5:0]   irq_mask6;
    logic         irq6;
    logic         err_oob6;

    always #5 clk = ~clk;

    mem_io_bridge u_dut (
        .clk(clk), .rst_n(rst_n),
        .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_port(hw_port), .hw_data(hw_data),
        .io_hold(io_hold), .io_active_in(io_active_in), .io_data_in(io_data_in),
        .io_active_out(io_active_out), .io_data_out(io_data_out),
        .hr_req(hr_req), .hr_port(hr_port), .hr_valid(hr_valid), .hr_data(hr_data),
        .hr_fresh(hr_fresh), .irq_mask(irq_mask), .irq(irq), .err_oob(err_oob)
    );

    mem_io_bridge #(.NUM_PORTS(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .hw_valid(hw_valid6), .hw_ready(hw_ready6), .hw_port(hw_port6), .hw_data(hw_data6),
        .io_hold(io_hold6), .io_active_in(io_active_in6), .io_data_in(io_data_in6),
        .io_active_out(io_active_out6), .io_data_out(io_data_out6),
        .hr_req(hr_req6), .hr_port(hr_port6), .hr_valid(hr_valid6), .hr_data(hr_data6),
        .hr_fresh(hr_fresh6), .irq_mask(irq_mask6), .irq(irq6), .err_oob(err_oob6)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Every io_active_in pulse must match the oldest accepted write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io_active_in != '0) begin
                if (sb.size() == 0) begin
                    chk("unexp_pulse", 128'(io_active_in), 128'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_port", 128'(io_active_in), 128'(8'd1 << mon_e.port));
                    chk("pulse_data", io_data_in, 128'(mon_e.data) << (16 * mon_e.port));
                end
            end else begin
                chk("idle_data", io_data_in, 128'd0);
            end
        end
    end

    // Starts and ends just after a falling edge.
    task automatic hw_write(input logic [2:0] p, input logic [15:0] d);
        int n = 0;
        exp_t e;
        hw_valid = 1'b1;
        hw_port  = p;
        hw_data  = d;
        while (!hw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!hw_ready) begin
            chk("wr_timeout", 128'(hw_ready), 128'd1);
        end else begin
            @(posedge clk);
            e.port = int'(p);
            e.data = d;
            sb.push_back(e);
        end
        @(negedge clk);
        hw_valid = 1'b0;
    endtask

    task automatic capture(input logic [7:0] ports, input logic [127:0] data);
        io_active_out = ports;
        io_data_out   = data;
        @(negedge clk);
        io_active_out = '0;
        io_data_out   = '0;
    endtask

    task automatic host_read(input logic [2:0] p);
        hr_req  = 1'b1;
        hr_port = p;
        @(negedge clk);
        hr_req  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        hw_valid = 0; hw_port = 0; hw_data = 0; io_hold = 0;
        io_active_out = 0; io_data_out = 0; hr_req = 0; hr_port = 0; irq_mask = 8'hFF;
        hw_valid6 = 0; hw_port6 = 0; hw_data6 = 0; io_hold6 = 0;
        io_active_out6 = 0; io_data_out6 = 0; hr_req6 = 0; hr_port6 = 0; irq_mask6 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_ready",  128'(hw_ready), 128'd1);
        chk("rst_active", 128'(io_active_in), 128'd0);
        chk("rst_data",   io_data_in, 128'd0);
        chk("rst_hvalid", 128'(hr_valid), 128'd0);
        chk("rst_hdata",  128'(hr_data), 128'd0);
        chk("rst_irq",    128'(irq), 128'd0);
        chk("rst_err",    128'(err_oob), 128'd0);

        // Single write and its latency.
        hw_write(3'd3, 16'hA5A5);
        chk("lat_k",   128'(io_active_in), 128'd0);
        @(negedge clk);
        chk("lat_k1",  128'(io_active_in), 128'h08);
        chk("lat_dat", io_data_in, 128'hA5A5 << 48);
        @(negedge clk);
        chk("lat_k2",  128'(io_active_in), 128'd0);

        // Fill under hold, backpressure, then back-to-back drain.
        io_hold = 1'b1;
        hw_write(3'd0, 16'h1111);
        hw_write(3'd1, 16'h2222);
        hw_write(3'd6, 16'h3333);
        hw_write(3'd2, 16'h4444);
        chk("full_ready", 128'(hw_ready), 128'd0);
        hw_valid = 1'b1; hw_port = 3'd5; hw_data = 16'h5555;
        repeat (2) @(negedge clk);
        chk("held_ready", 128'(hw_ready), 128'd0);
        chk("hold_quiet", 128'(io_active_in), 128'd0);
        io_hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_0", 128'(io_active_in != 0), 128'd1);
        chk("ready_pop", 128'(hw_ready), 128'd1);
        @(posedge clk);
        begin
            exp_t e;
            e.port = 5;
            e.data = 16'h5555;
            sb.push_back(e);
        end
        @(negedge clk);
        hw_valid = 1'b0;
        chk("b2b_1", 128'(io_active_in != 0), 128'd1);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_%0d", i), 128'(io_active_in != 0), 128'd1);
        end
        @(negedge clk);
        chk("drained", 128'(io_active_in), 128'd0);
        chk("sb_empty", 128'(sb.size()), 128'd0);

        // Out-of-range write on the six-port instance.
        io_hold6 = 1'b1;
        hw_valid6 = 1'b1; hw_port6 = 3'd7; hw_data6 = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        chk("oob_err",   128'(err_oob6), 128'd1);
        chk("oob_ready", 128'(hw_ready6), 128'd1);
        hw_port6 = 3'd1; hw_data6 = 16'h0077;
        @(posedge clk);
        @(negedge clk);
        hw_valid6 = 1'b0;
        io_hold6  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("oob_first", 128'(io_active_in6), 128'h02);
        chk("oob_fdata", 128'(io_data_in6), 128'h0077 << 16);
        @(negedge clk);
        chk("oob_after", 128'(io_active_in6), 128'd0);
        chk("oob_stick", 128'(err_oob6), 128'd1);
        hr_req6 = 1'b1; hr_port6 = 3'd7;
        @(negedge clk);
        hr_req6 = 1'b0;
        chk("oob_rvalid", 128'(hr_valid6), 128'd1);
        chk("oob_rfresh", 128'(hr_fresh6), 128'd0);

        // Capture and readback.
        capture(8'h04, 128'h1234 << 32);
        chk("cap_irq", 128'(irq), 128'd1);
        irq_mask = 8'hFB;
        #1;
        chk("cap_irq_mask", 128'(irq), 128'd0);
        irq_mask = 8'hFF;
        host_read(3'd2);
        chk("rd_valid", 128'(hr_valid), 128'd1);
        chk("rd_data",  128'(hr_data), 128'h1234);
        chk("rd_fresh", 128'(hr_fresh), 128'd1);
        chk("rd_irq",   128'(irq), 128'd0);
        host_read(3'd2);
        chk("rd2_data",  128'(hr_data), 128'h1234);
        chk("rd2_fresh", 128'(hr_fresh), 128'd0);
        @(negedge clk);
        chk("rd_idle", 128'(hr_valid), 128'd0);

        // Two ports capturing in the same cycle.
        capture(8'h81, (128'h77BB << 112) | 128'h00AA);
        host_read(3'd7);
        chk("multi7", 128'({hr_fresh, hr_data}), 128'h1_77BB);
        host_read(3'd0);
        chk("multi0", 128'({hr_fresh, hr_data}), 128'h1_00AA);

        // Read and capture on the same port at the same edge.
        capture(8'h20, 128'h0001 << 80);
        hr_req = 1'b1; hr_port = 3'd5;
        io_active_out = 8'h20; io_data_out = 128'h0BEE << 80;
        @(negedge clk);
        hr_req = 1'b0; io_active_out = 0; io_data_out = 0;
        chk("col_data",  128'(hr_data), 128'h0001);
        chk("col_fresh", 128'(hr_fresh), 128'd1);
        chk("col_irq",   128'(irq), 128'd1);
        host_read(3'd5);
        chk("col_after", 128'({hr_fresh, hr_data}), 128'h1_0BEE);

        // Reset with entries queued.
        capture(8'h10, 128'h4444 << 64);
        io_hold = 1'b1;
        hw_write(3'd1, 16'hAAAA);
        hw_write(3'd2, 16'hBBBB);
        hw_write(3'd3, 16'hCCCC);
        rst_n = 1'b0;
        io_hold = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_ready", 128'(hw_ready), 128'd1);
        chk("mrst_act",   128'(io_active_in), 128'd0);
        chk("mrst_hdata", 128'(hr_data), 128'd0);
        chk("mrst_fresh", 128'(hr_fresh), 128'd0);
        chk("mrst_irq",   128'(irq), 128'd0);
        chk("mrst_err6",  128'(err_oob6), 128'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("mrst_quiet", 128'(io_active_in), 128'd0);
        end
        host_read(3'd4);
        chk("mrst_cap", 128'({hr_fresh, hr_data}), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
